// File: rtl/spi_esclavo.sv
// SPI mode-0 responder, oversampled on spi_clk_i, with a one-entry TX buffer.
// Optional sticky error flags (spi_err_o / spi_errclr_i) when SPI_ESCLAVO_ERRFLAG_EN is defined.
module spi_esclavo #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  spi_clk_i,
  input  logic                  spi_rst_i,
  input  logic                  SCK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe_o,
  input  logic                  spi_fbo_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [7:0]            byte_cnt_o,
  output logic                  busy_o
`ifdef SPI_ESCLAVO_ERRFLAG_EN
  ,
  output logic [1:0]            spi_err_o,
  input  logic                  spi_errclr_i
`endif
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StReload} state_e;

  state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                  sck_prev_q, ss_prev_q;
  logic                  fbo_q, fbo_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;

  logic                  sck_s, ss_s, mosi_s;
  logic                  sck_rise, sck_fall, ss_rise, ss_fall;
  logic                  load, underrun, abort, tx_write;
  logic [DATA_WIDTH-1:0] tx_word, rx_next;

  // Synchronizers plus one extra stage for edge detection; SS idles high.
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  assign tx_word  = buf_full_q ? buf_q : IDLE_FILL;
  assign tx_write = tx_valid_i & ~buf_full_q;

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      state_q    <= StIdle;
      fbo_q      <= 1'b1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      oe_q       <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fbo_q      <= fbo_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      oe_q       <= oe_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fbo_d      = fbo_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    oe_d       = oe_q;
    load       = 1'b0;
    abort      = 1'b0;
    rx_next    = fbo_q ? {rx_sh_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sh_q[DATA_WIDTH-1:1]};

    if (ss_rise) begin
      // Frame end wins over any same-cycle SCK edge; a partial word is dropped.
      abort   = (state_q == StShift) && (bit_cnt_q != '0);
      state_d = StIdle;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            fbo_d      = spi_fbo_i;
            load       = 1'b1;
            tx_sh_d    = tx_word;
            oe_d       = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = StShift;
          end
        end
        StShift: begin
          if (sck_rise) begin
            rx_sh_d = rx_next;
            if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
              state_d    = StReload;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end else if (sck_fall && (bit_cnt_q != '0)) begin
            tx_sh_d = fbo_q ? {tx_sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
          end
        end
        StReload: begin
          if (sck_fall) begin
            load    = 1'b1;
            tx_sh_d = tx_word;
            state_d = StShift;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign underrun = load & ~buf_full_q;

  // A load only ever sees the pre-write buffer state, so write and load never collide.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (load && buf_full_q) buf_full_d = 1'b0;
    if (tx_write) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end
  end

  assign MISO       = oe_q ? (fbo_q ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0]) : 1'b1;
  assign miso_oe_o  = oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = ~buf_full_q;
  assign byte_cnt_o = byte_cnt_q;
  assign busy_o     = ~ss_s;

`ifdef SPI_ESCLAVO_ERRFLAG_EN
  logic [1:0] err_q, err_d;

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    err_d = err_q;
    if (spi_errclr_i) err_d = 2'b00;
    err_d = err_d | {abort, underrun};
  end

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) err_q <= 2'b00;
    else           err_q <= err_d;
  end

  assign spi_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = underrun ^ abort;
`endif

endmodule

// File: tb/tb_spi_esclavo.sv
// Bench for spi_esclavo: directed SPI frames, scoreboard queues for received words and MISO words.
module tb_spi_esclavo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic       fbo = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] byte_cnt;
  logic       busy;
`ifdef SPI_ESCLAVO_ERRFLAG_EN
  logic [1:0] err;
  logic       errclr = 1'b0;
`endif

  spi_esclavo #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .IDLE_FILL  (8'hFF)
  ) dut (
    .spi_clk_i (clk),
    .spi_rst_i (rst),
    .SCK       (sck),
    .SS        (ss),
    .MOSI      (mosi),
    .MISO      (miso),
    .miso_oe_o (miso_oe),
    .spi_fbo_i (fbo),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .byte_cnt_o(byte_cnt),
    .busy_o    (busy)
`ifdef SPI_ESCLAVO_ERRFLAG_EN
    ,
    .spi_err_o   (err),
    .spi_errclr_i(errclr)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] miso_exp_q[$];
  logic       cur_fbo = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every rx_valid strobe must match the next expected received word.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got strobe with 0x%0h, expected none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
      end
    end
  end

  // Monitor: master-side view of MISO, sampled on SCK rising edges; partial words dropped.
  initial begin
    int         nb;
    logic [7:0] w;
    nb = 0;
    w  = 8'h00;
    forever begin
      @(posedge sck or posedge ss);
      if (ss) begin
        nb = 0;
      end else begin
        w = cur_fbo ? {w[6:0], miso} : {miso, w[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (miso_exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL miso_unexpected: got word 0x%0h, expected none", w);
          end else begin
            check("miso_word", 32'(w), 32'(miso_exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    check("tx_ready_before_write", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_write", 32'(tx_ready), 0);
  endtask

  task automatic ss_begin(input logic f);
    fbo     = f;
    cur_fbo = f;
    ss      = 1'b0;
    wait_clks(10);
    check("miso_oe_in_frame", 32'(miso_oe), 1);
    check("busy_in_frame", 32'(busy), 1);
  endtask

  task automatic ss_end();
    wait_clks(4);
    ss = 1'b1;
    wait_clks(10);
    check("miso_oe_after_frame", 32'(miso_oe), 0);
    check("miso_after_frame", 32'(miso), 1);
    check("busy_after_frame", 32'(busy), 0);
  endtask

  // SCK half period is 6 spi_clk cycles; MOSI changes while SCK is low.
  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = cur_fbo ? w[3'(7 - i)] : w[3'(i)];
      #60 sck = 1'b1;
      #60 sck = 1'b0;
    end
    #60;
  endtask

  initial begin
    #1 rst = 1'b1;
    wait_clks(3);
    check("rst_miso", 32'(miso), 1);
    check("rst_miso_oe", 32'(miso_oe), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_byte_cnt", 32'(byte_cnt), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef SPI_ESCLAVO_ERRFLAG_EN
    check("rst_err", 32'(err), 0);
`endif
    rst = 1'b0;
    wait_clks(5);

    // 1: MSB first, buffered 3C, master sends A5.
    tx_write(8'h3C);
    rx_exp_q.push_back(8'hA5);
    miso_exp_q.push_back(8'h3C);
    ss_begin(1'b1);
    check("t1_tx_ready_after_load", 32'(tx_ready), 1);
    send_bits(8'hA5, 8);
    check("t1_byte_cnt", 32'(byte_cnt), 1);
    ss_end();

    // 2: LSB first, buffered 01, master sends 80.
    tx_write(8'h01);
    rx_exp_q.push_back(8'h80);
    miso_exp_q.push_back(8'h01);
    ss_begin(1'b0);
    send_bits(8'h80, 8);
    check("t2_byte_cnt", 32'(byte_cnt), 1);
    ss_end();

    // 3: two-word frame, buffer refilled with 12 after the first load.
    tx_write(8'hC3);
    rx_exp_q.push_back(8'h5C);
    rx_exp_q.push_back(8'h3E);
    miso_exp_q.push_back(8'hC3);
    miso_exp_q.push_back(8'h12);
    ss_begin(1'b1);
    check("t3_byte_cnt_start", 32'(byte_cnt), 0);
    tx_write(8'h12);
    send_bits(8'h5C, 8);
    check("t3_byte_cnt_1", 32'(byte_cnt), 1);
    check("t3_tx_ready_reload", 32'(tx_ready), 1);
    send_bits(8'h3E, 8);
    check("t3_byte_cnt_2", 32'(byte_cnt), 2);
    ss_end();

    // 4: empty buffer -> IDLE_FILL shifted out.
`ifdef SPI_ESCLAVO_ERRFLAG_EN
    errclr = 1'b1;
    @(negedge clk);
    errclr = 1'b0;
    check("t4_err_cleared", 32'(err), 0);
`endif
    rx_exp_q.push_back(8'h33);
    miso_exp_q.push_back(8'hFF);
    ss_begin(1'b1);
    send_bits(8'h33, 8);
    ss_end();
`ifdef SPI_ESCLAVO_ERRFLAG_EN
    check("t4_err_underrun", 32'(err[0]), 1);
    errclr = 1'b1;
    @(negedge clk);
    errclr = 1'b0;
`endif

    // 5: frame aborted after 5 bits, then a clean 5A frame.
    ss_begin(1'b1);
    send_bits(8'hC7, 5);
    ss_end();
    check("t5_rx_data_held", 32'(rx_data), 'h33);
`ifdef SPI_ESCLAVO_ERRFLAG_EN
    check("t5_err_abort", 32'(err[1]), 1);
`endif
    rx_exp_q.push_back(8'h5A);
    miso_exp_q.push_back(8'hFF);
    ss_begin(1'b1);
    send_bits(8'h5A, 8);
    ss_end();
    check("t5_rx_data_after", 32'(rx_data), 'h5A);

    // 6: reset mid-word with a full buffer, then a clean frame.
    tx_write(8'hAA);
    ss_begin(1'b1);
    tx_write(8'h55);
    send_bits(8'hF0, 3);
    rst = 1'b1;
    #1;
    check("t6_rst_miso", 32'(miso), 1);
    check("t6_rst_miso_oe", 32'(miso_oe), 0);
    check("t6_rst_rx_data", 32'(rx_data), 0);
    check("t6_rst_rx_valid", 32'(rx_valid), 0);
    check("t6_rst_tx_ready", 32'(tx_ready), 1);
    check("t6_rst_byte_cnt", 32'(byte_cnt), 0);
    check("t6_rst_busy", 32'(busy), 0);
    #9;
    ss = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);
    tx_write(8'h69);
    rx_exp_q.push_back(8'h96);
    miso_exp_q.push_back(8'h69);
    ss_begin(1'b1);
    send_bits(8'h96, 8);
    check("t6_byte_cnt", 32'(byte_cnt), 1);
    ss_end();

    for (int i = 0; i < 200 && (rx_exp_q.size() != 0 || miso_exp_q.size() != 0); i++) begin
      @(negedge clk);
    end
    while (rx_exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_missing: got no strobe, expected 0x%0h", rx_exp_q.pop_front());
    end
    while (miso_exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL miso_missing: got no word, expected 0x%0h", miso_exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
